// File: rtl/play_arbiter.sv
// play_arbiter
//   Chooses which of three note/LED sources (free, auto, learn) drives the
//   buzzer and LED outputs. Every change of owner goes through a silent gap
//   of MUTE_CYCLES clocks. The outputs are forced to zero during that gap so
//   that no source that is not granted ever reaches them.
//
//   Optional feature: define NOTE_WATCHDOG_EN to build a stuck-note watchdog.
//   When the same nonzero note has been forwarded for WDOG_CYCLES consecutive
//   cycles, the output is silenced until the source note changes.
//
// Ports
//   clk                        system clock, rising edge
//   reset                      asynchronous, active-low reset
//   mode[2:0]                  one-hot owner request (100 free, 010 auto, 001 learn)
//   free/auto/learn_note[3:0]  source notes (0 = rest, 1-7 = notes, 8-15 sent as 0)
//   free/auto/learn_led[6:0]   source LED patterns
//   note_out[3:0]              registered note to the buzzer driver
//   led_out[6:0]               registered LED pattern
//   grant[2:0]                 one-hot current owner, 000 when there is no owner
//   busy                       high during the mute gap
//   auto_start / learn_start   one-cycle restart pulse on the first ACTIVE cycle
//   o_dbg_state[1:0]           current FSM state (0 IDLE, 1 MUTE, 2 ACTIVE)
//
// Handshake: no valid/ready pair exists here. mode is a level request, sampled
// on every clock edge. The request is granted only after it has stayed stable
// through a full gap.
module play_arbiter #(
  parameter int MUTE_CYCLES = 1000,
  parameter int WDOG_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic [3:0] free_note,
  input  logic [3:0] auto_note,
  input  logic [3:0] learn_note,
  input  logic [6:0] free_led,
  input  logic [6:0] auto_led,
  input  logic [6:0] learn_led,
  output logic [3:0] note_out,
  output logic [6:0] led_out,
  output logic [2:0] grant,
  output logic       busy,
  output logic       auto_start,
  output logic       learn_start,
  output logic [1:0] o_dbg_state
);

  localparam int CW = $clog2(MUTE_CYCLES + 1);
  localparam logic [CW-1:0] MUTE_LOAD = CW'(MUTE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUTE = 2'd1, S_ACTIVE = 2'd2} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_req, w_req_nx;
  logic [2:0]    r_grant, w_grant_nx;
  logic [3:0]    r_note, w_note_nx;
  logic [6:0]    r_led, w_led_nx;
  logic          r_busy, w_busy_nx;
  logic          r_auto, w_auto_nx;
  logic          r_learn, w_learn_nx;

  logic          w_mode_valid;
  logic [3:0]    w_src_note;
  logic [6:0]    w_src_led;
  logic [3:0]    w_src_fwd;

  assign w_mode_valid = (mode == 3'b100) || (mode == 3'b010) || (mode == 3'b001);

  // Only the registered grant selects a source. While the FSM is not in
  // ACTIVE, r_grant is 000, so the selected value is zero.
  always_comb begin
    w_src_note = '0;
    w_src_led  = '0;
    case (r_grant)
      3'b100:  begin w_src_note = free_note;  w_src_led = free_led;  end
      3'b010:  begin w_src_note = auto_note;  w_src_led = auto_led;  end
      3'b001:  begin w_src_note = learn_note; w_src_led = learn_led; end
      default: begin w_src_note = '0;         w_src_led = '0;        end
    endcase
  end

  // Values 8-15 are not playable notes and are sent as a rest.
  assign w_src_fwd = w_src_note[3] ? 4'd0 : w_src_note;

`ifdef NOTE_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] r_wd_cnt, w_wd_cnt_nx;   // cycles the current nonzero note has been played
  logic [3:0]    r_wd_prev, w_wd_prev_nx; // forwarded note seen on the previous ACTIVE cycle
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES == 0);
`endif

  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_req;
    w_cnt_nx   = r_cnt;
    w_grant_nx = '0;
    w_note_nx  = '0;
    w_led_nx   = '0;
    w_busy_nx  = 1'b0;
    w_auto_nx  = 1'b0;
    w_learn_nx = 1'b0;
`ifdef NOTE_WATCHDOG_EN
    w_wd_cnt_nx  = '0;
    w_wd_prev_nx = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_mode_valid) begin
          w_state_nx = S_MUTE;
          w_req_nx   = mode;
          w_cnt_nx   = MUTE_LOAD;
          w_busy_nx  = 1'b1;
        end
      end
      S_MUTE: begin
        if (!w_mode_valid) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (mode != r_req) begin
          // A new request restarts the gap from the beginning.
          w_req_nx  = mode;
          w_cnt_nx  = MUTE_LOAD;
          w_busy_nx = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nx = S_ACTIVE;
          w_grant_nx = r_req;
          w_auto_nx  = (r_req == 3'b010);
          w_learn_nx = (r_req == 3'b001);
        end else begin
          w_cnt_nx  = r_cnt - CW'(1);
          w_busy_nx = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!w_mode_valid) begin
          w_state_nx = S_IDLE;
        end else if (mode != r_grant) begin
          w_state_nx = S_MUTE;
          w_req_nx   = mode;
          w_cnt_nx   = MUTE_LOAD;
          w_busy_nx  = 1'b1;
        end else begin
          w_grant_nx = r_grant;
          w_led_nx   = w_src_led;
`ifdef NOTE_WATCHDOG_EN
          w_wd_prev_nx = w_src_fwd;
          if ((w_src_fwd == 4'd0) || (w_src_fwd != r_wd_prev)) begin
            w_wd_cnt_nx = (w_src_fwd != 4'd0) ? WW'(1) : '0;
            w_note_nx   = w_src_fwd;
          end else if (r_wd_cnt >= WW'(WDOG_CYCLES)) begin
            // Stuck note: hold silence and keep the count saturated.
            w_wd_cnt_nx = r_wd_cnt;
            w_note_nx   = 4'd0;
          end else begin
            w_wd_cnt_nx = r_wd_cnt + WW'(1);
            w_note_nx   = w_src_fwd;
          end
`else
          w_note_nx = w_src_fwd;
`endif
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_grant <= '0;
      r_note  <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_auto  <= 1'b0;
      r_learn <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_req   <= w_req_nx;
      r_grant <= w_grant_nx;
      r_note  <= w_note_nx;
      r_led   <= w_led_nx;
      r_busy  <= w_busy_nx;
      r_auto  <= w_auto_nx;
      r_learn <= w_learn_nx;
    end
  end

`ifdef NOTE_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt  <= '0;
      r_wd_prev <= '0;
    end else begin
      r_wd_cnt  <= w_wd_cnt_nx;
      r_wd_prev <= w_wd_prev_nx;
    end
  end
`endif

  assign note_out    = r_note;
  assign led_out     = r_led;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign auto_start  = r_auto;
  assign learn_start = r_learn;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_play_arbiter.sv
module tb_play_arbiter;

  localparam int MUTE = 4;
  localparam int WDOG = 8;

  logic       clk;
  logic       reset;
  logic [2:0] mode;
  logic [3:0] free_note, auto_note, learn_note;
  logic [6:0] free_led, auto_led, learn_led;
  logic [3:0] note_out;
  logic [6:0] led_out;
  logic [2:0] grant;
  logic       busy, auto_start, learn_start;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: owner bookkeeping in terms of "gap cycles still to show"
  bit         m_in_gap, m_active;
  int         m_left;     // busy cycles remaining including the one just shown
  logic [2:0] m_req;
  int         m_run;      // consecutive ACTIVE cycles with the same nonzero note
  logic [3:0] m_last;
  logic [3:0] e_note;
  logic [6:0] e_led;
  logic [2:0] e_grant;
  logic       e_busy, e_as, e_ls;

  play_arbiter #(.MUTE_CYCLES(MUTE), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .free_note(free_note), .auto_note(auto_note), .learn_note(learn_note),
    .free_led(free_led), .auto_led(auto_led), .learn_led(learn_led),
    .note_out(note_out), .led_out(led_out), .grant(grant), .busy(busy),
    .auto_start(auto_start), .learn_start(learn_start), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] filt(input logic [3:0] n);
    return (n > 4'd7) ? 4'd0 : n;
  endfunction

  task automatic model_clear();
    m_in_gap = 0; m_active = 0; m_left = 0; m_req = '0; m_run = 0; m_last = '0;
    e_note = '0; e_led = '0; e_grant = '0; e_busy = 0; e_as = 0; e_ls = 0;
  endtask

  task automatic model_step();
    bit         valid;
    logic [3:0] f;
    logic [6:0] l;
    valid = (mode == 3'b100) || (mode == 3'b010) || (mode == 3'b001);
    e_note = '0; e_led = '0; e_grant = '0; e_as = 0; e_ls = 0;
    if (!reset) begin
      model_clear();
      return;
    end
    if (m_active) begin
      if (!valid) m_active = 0;
      else if (mode != m_req) begin
        m_active = 0; m_in_gap = 1; m_req = mode; m_left = MUTE;
      end else begin
        e_grant = m_req;
        f = '0; l = '0;
        if (m_req == 3'b100) begin f = filt(free_note);  l = free_led;  end
        if (m_req == 3'b010) begin f = filt(auto_note);  l = auto_led;  end
        if (m_req == 3'b001) begin f = filt(learn_note); l = learn_led; end
        if (f == 0 || f != m_last) m_run = (f != 0) ? 1 : 0;
        else if (m_run <= WDOG) m_run++;
        m_last = f;
`ifdef NOTE_WATCHDOG_EN
        e_note = (m_run > WDOG) ? 4'd0 : f;
`else
        e_note = f;
`endif
        e_led = l;
      end
      if (!m_active) begin m_run = 0; m_last = '0; end
    end else if (m_in_gap) begin
      if (!valid) m_in_gap = 0;
      else if (mode != m_req) begin m_req = mode; m_left = MUTE; end
      else if (m_left == 1) begin
        m_in_gap = 0; m_active = 1; e_grant = m_req;
        e_as = (m_req == 3'b010); e_ls = (m_req == 3'b001);
        m_run = 0; m_last = '0;
      end else m_left--;
    end else if (valid) begin
      m_in_gap = 1; m_req = mode; m_left = MUTE;
    end
    e_busy = m_in_gap;
  endtask

  // scoreboard: compare every output against the model each cycle
  task automatic check_outputs();
    check_eq("note_out", 8'(note_out), 8'(e_note));
    check_eq("led_out", 8'(led_out), 8'(e_led));
    check_eq("grant", 8'(grant), 8'(e_grant));
    check_eq("busy", 8'(busy), 8'(e_busy));
    check_eq("auto_start", 8'(auto_start), 8'(e_as));
    check_eq("learn_start", 8'(learn_start), 8'(e_ls));
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_note"}, 8'(note_out), 8'd0);
    check_eq({tag, "_led"}, 8'(led_out), 8'd0);
    check_eq({tag, "_grant"}, 8'(grant), 8'd0);
    check_eq({tag, "_busy"}, 8'(busy), 8'd0);
    check_eq({tag, "_starts"}, 8'({auto_start, learn_start}), 8'd0);
    check_eq({tag, "_state"}, 8'(dbg_state), 8'd0);
  endtask

  // assert reset between edges, check the asynchronous clear, hold two edges
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero(tag);
    model_clear();
    run(2);
    reset = 1'b1;
  endtask

  task automatic rand_sources();
    free_note  = 4'($urandom_range(0, 15));
    auto_note  = 4'($urandom_range(0, 15));
    learn_note = 4'($urandom_range(0, 15));
    free_led   = 7'($urandom_range(0, 127));
    auto_led   = 7'($urandom_range(0, 127));
    learn_led  = 7'($urandom_range(0, 127));
  endtask

  int         busy_cnt, as_cnt, ls_cnt;
  logic [2:0] mode_tbl[8];

  initial begin
    mode_tbl[0] = 3'b100; mode_tbl[1] = 3'b010; mode_tbl[2] = 3'b001;
    mode_tbl[3] = 3'b100; mode_tbl[4] = 3'b010; mode_tbl[5] = 3'b001;
    mode_tbl[6] = 3'b011; mode_tbl[7] = 3'b000;
    reset = 1'b0; mode = '0;
    free_note = '0; auto_note = '0; learn_note = '0;
    free_led = '0; auto_led = '0; learn_led = '0;
    model_clear();
    #1;
    check_all_zero("reset");
    run(2);

    // first owner after reset: auto
    mode = 3'b010; auto_note = 4'd5; auto_led = 7'h2A;
    reset = 1'b1;
    busy_cnt = 0; as_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (busy) busy_cnt++;
      if (auto_start) as_cnt++;
    end
    check_eq("first_gap_len", 8'(busy_cnt), 8'd4);
    check_eq("first_auto_pulses", 8'(as_cnt), 8'd1);

    // handover auto -> learn
    mode = 3'b001; learn_note = 4'd2; learn_led = 7'h11;
    busy_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (busy) busy_cnt++;
      if (learn_start) ls_cnt++;
    end
    check_eq("handover_gap_len", 8'(busy_cnt), 8'd4);
    check_eq("handover_learn_pulses", 8'(ls_cnt), 8'd1);

    // request change late in the gap restarts it
    mode = 3'b010;
    run(3);
    mode = 3'b100; free_note = 4'd6; free_led = 7'h55;
    busy_cnt = 0; as_cnt = 0; ls_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (busy) busy_cnt++;
      if (auto_start) as_cnt++;
      if (learn_start) ls_cnt++;
    end
    check_eq("restart_gap_len", 8'(busy_cnt), 8'd4);
    check_eq("restart_no_pulse", 8'(as_cnt + ls_cnt), 8'd0);

    // out-of-range note, then invalid mode
    free_note = 4'd12;
    run(2);
    mode = 3'b011;
    run(3);

    // reset in the middle of the gap, then in the middle of ACTIVE
    mode = 3'b010; auto_note = 4'd7;
    run(2);
    async_reset("rst_mute");
    run(6);
    async_reset("rst_active");

    // stuck note watchdog
    mode = 3'b001; learn_note = 4'd3;
    run(5);
    run(12);
    learn_note = 4'd4;
    run(3);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      int hold;
      mode = mode_tbl[$urandom_range(0, 7)];
      hold = $urandom_range(1, 10);
      for (int j = 0; j < hold; j++) begin
        if ($urandom_range(0, 3) == 0) rand_sources();
        cycle();
      end
      if ($urandom_range(0, 49) == 0) async_reset("rst_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
